lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side companion of the lfsr generator: accepts one NBITS-wide LFSR state word per valid cycle,
//  self-synchronises to the sequence, then checks every following word against its own prediction.
//  Sits at the consumer end of the generator's q output (loopback, replay-buffer integrity checks).
//  Reports lock status, per-word mismatch strobe and saturating error/word counters.
// PARAMETERS
//  NBITS      16        word/LFSR width; must match the generator
//  TAPS       16'hB400  feedback mask (x^16+x^14+x^13+x^11); must match the generator
//  LOCK_CNT   4         consecutive correct predictions needed to declare lock (1..15)
//  LOSS_CNT   3         consecutive mismatches while locked that drop lock (1..15)
//  CNTW       16        width of err_cnt / word_cnt
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-low (rst==0 at a clk edge resets)
//  valid     in   1      din carries a generator word this cycle
//  din       in   NBITS  received LFSR state word
//  clr_cnt   in   1      synchronous clear of err_cnt and word_cnt
//  locked    out  1      1 while in LOCKED state
//  err       out  1      one-cycle strobe: mismatch on a word checked in LOCKED
//  err_cnt   out  CNTW   mismatches counted in LOCKED, saturates at all-ones
//  word_cnt  out  CNTW   valid words counted in LOCKED, saturates at all-ones
//  expected  out  NBITS  prediction for the next valid word
// BEHAVIOUR
//  - Step function: nxt(s) = {s[NBITS-2:0], ^(s & TAPS)}; identical to the generator's per-clock update.
//  - All outputs registered; reset values: locked=0, err=0, err_cnt=0, word_cnt=0, expected=0, state=HUNT.
//  - Only cycles with valid=1 advance anything; valid=0 holds all state (err deasserts next cycle).
//  - FSM (registered, updated on valid cycles):
//     HUNT   : din==0 ignored (illegal LFSR state). Otherwise expected<=nxt(din), match_cnt<=0 -> SYNC.
//     SYNC   : din==expected: expected<=nxt(din), match_cnt+1; reaching LOCK_CNT -> LOCKED.
//              mismatch: reseed from din (expected<=nxt(din), match_cnt<=0), stay SYNC; din==0 -> HUNT.
//     LOCKED : word_cnt+1 each word. Match: miss_cnt<=0. Mismatch: err=1 next cycle, err_cnt+1, miss_cnt+1.
//              expected<=nxt(expected) regardless of outcome (a single bit error must not desync).
//              miss_cnt reaching LOSS_CNT -> HUNT, locked<=0 on the same edge.
//  - Latency: din sampled at edge N -> err/counters/locked updated at edge N (visible after N).
//  - Word counted in the LOCK_CNT-reaching cycle is not counted in word_cnt; counting starts the next word.
//  - Counters saturate, never wrap. clr_cnt simultaneous with an increment: clear wins (result 0).
//  - clr_cnt does not affect the FSM, locked, or expected.
//  - Reset mid-operation (any state): everything to reset values on that edge; valid ignored that cycle.
//  - Lock loss does not clear err_cnt/word_cnt; only rst or clr_cnt do.
// STRUCTURE
//  - Shared package/header (lfsr_defs): FSM state encoding {HUNT,SYNC,LOCKED}, default TAPS and NBITS,
//    so generator and checker share one definition of the polynomial.
//  - Sub-module lfsr_next (combinational, params NBITS/TAPS): s -> nxt(s); instanced once on the
//    din/expected mux. The generator should reuse the same sub-module.
//  - Checker core: FSM, match/miss counters (4 bit), saturating CNTW counters, expected register.
// TESTING
//  1. Reset, then clean generator stream seed 16'h0009 valid every cycle -> locked=1 after 1+LOCK_CNT
//     words (5th valid word), err never asserted, word_cnt counts subsequent words exactly.
//  2. Locked, flip bit 0 of one word -> err pulse 1 cycle, err_cnt=1, locked stays 1, next word matches.
//  3. Locked, feed 3 consecutive wrong words -> err_cnt=3, locked=0 after 3rd, re-lock within 5 good words.
//  4. In HUNT drive din=0 for 10 cycles then valid stream -> no state change during zeros, then normal lock.
//  5. valid toggled 1/0 alternately with a correct stream -> lock and check unaffected by gaps.
//  6. CNTW=4: 20 errors while locked -> err_cnt saturates at 4'hF; clr_cnt with error same cycle -> 0;
//     rst=0 mid-LOCKED -> all outputs 0 next cycle, state HUNT.

Source files
------------

// File: rtl/lfsr_defs_pkg.sv
// Shared LFSR definitions: default polynomial/width and checker FSM encoding.
// Generator and checker import this so both sides agree on one polynomial.
package lfsr_defs;

  localparam int          NBITS_DEF = 16;
  localparam logic [15:0] TAPS_DEF  = 16'hB400;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr_next.sv
// One LFSR step, purely combinational (zero latency, no flow control).
// Shared by generator and checker so both advance identically.
module lfsr_next
  import lfsr_defs::*;
#(
  parameter int               NBITS = NBITS_DEF,
  parameter logic [NBITS-1:0] TAPS  = TAPS_DEF
) (
  input  logic [NBITS-1:0] s,
  output logic [NBITS-1:0] nxt
);

  assign nxt = {s[NBITS-2:0], ^(s & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// LFSR stream checker: hunts, syncs and locks to the sequence, then flags mismatches.
// din sampled on a valid edge updates all registered outputs on that edge; no backpressure.
module lfsr_checker
  import lfsr_defs::*;
#(
  parameter int               NBITS    = NBITS_DEF,
  parameter logic [NBITS-1:0] TAPS     = TAPS_DEF,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3,
  parameter int               CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [NBITS-1:0] din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNTW-1:0]  err_cnt,
  output logic [CNTW-1:0]  word_cnt,
  output logic [NBITS-1:0] expected
);

  localparam logic [3:0]      LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0]      LOSS_C = 4'(LOSS_CNT);
  localparam logic [CNTW-1:0] CMAX   = '1;

  state_t           state, state_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic [3:0]       miss_cnt, miss_nxt;
  logic [NBITS-1:0] seed, pred, expected_nxt;
  logic [CNTW-1:0]  err_cnt_nxt, word_cnt_nxt;
  logic             err_nxt, locked_nxt;
  logic             hit, din_zero;

  assign hit      = (din == expected);
  assign din_zero = (din == '0);

  // Once locked, prediction free-runs from itself so isolated bit errors cannot desync it.
  assign seed = (state == LOCKED) ? expected : din;

  lfsr_next #(.NBITS(NBITS), .TAPS(TAPS)) u_next (
    .s   (seed),
    .nxt (pred)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      expected  <= expected_nxt;
      locked    <= locked_nxt;
      err       <= err_nxt;
      err_cnt   <= err_cnt_nxt;
      word_cnt  <= word_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    match_nxt    = match_cnt;
    miss_nxt     = miss_cnt;
    expected_nxt = expected;
    if (valid) begin
      case (state)
        HUNT: begin
          if (!din_zero) begin
            expected_nxt = pred;
            match_nxt    = '0;
            state_nxt    = SYNC;
          end
        end
        SYNC: begin
          if (hit) begin
            expected_nxt = pred;
            match_nxt    = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_C) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else if (din_zero) begin
            state_nxt = HUNT;
          end else begin
            expected_nxt = pred;
            match_nxt    = '0;
          end
        end
        LOCKED: begin
          expected_nxt = pred;
          if (hit) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = miss_cnt + 4'd1;
            if (miss_cnt + 4'd1 == LOSS_C) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    err_nxt      = valid && (state == LOCKED) && !hit;
    locked_nxt   = (state_nxt == LOCKED);
    err_cnt_nxt  = err_cnt;
    word_cnt_nxt = word_cnt;
    if (valid && (state == LOCKED)) begin
      if (word_cnt != CMAX) word_cnt_nxt = word_cnt + 1'b1;
      if (!hit && (err_cnt != CMAX)) err_cnt_nxt = err_cnt + 1'b1;
    end
    if (clr_cnt) begin
      err_cnt_nxt  = '0;
      word_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: stimulus pushes expected responses, a monitor pops and compares.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst, valid, clr_cnt;
  logic [15:0] din;
  logic        locked, err;
  logic [3:0]  err_cnt, word_cnt;
  logic [15:0] expected;

  always #5 clk = ~clk;

  lfsr_checker #(
    .NBITS(16), .TAPS(16'hB400), .LOCK_CNT(4), .LOSS_CNT(3), .CNTW(4)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt), .word_cnt(word_cnt),
    .expected(expected)
  );

  typedef struct {
    int          tst;
    int          stp;
    bit          chk_exp;
    logic        locked;
    logic        err;
    logic [3:0]  ec;
    logic [3:0]  wc;
    logic [15:0] expd;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          tst = 0;
  int          stp = 0;
  logic [15:0] g, gexp;
  logic [3:0]  ec, wc;

  // Reference step written bit by bit from the polynomial.
  function automatic logic [15:0] nxt_m(input logic [15:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 16; i++)
      if (i == 15 || i == 13 || i == 12 || i == 10) fb = fb ^ s[i];
    return {s[14:0], fb};
  endfunction

  task automatic chk1(input string nm, input exp_t e, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL t%0d s%0d %s: got %h want %h", e.tst, e.stp, nm, act, req);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [15:0] d, input logic c,
                     input logic lk, input logic er, input bit ce, input logic [15:0] xp);
    exp_t e;
    @(negedge clk);
    rst = r; valid = v; din = d; clr_cnt = c;
    stp++;
    e.tst = tst; e.stp = stp; e.chk_exp = ce;
    e.locked = lk; e.err = er; e.ec = ec; e.wc = wc; e.expd = xp;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        m = q.pop_front();
        chk1("locked",   m, {15'd0, locked}, {15'd0, m.locked});
        chk1("err",      m, {15'd0, err},    {15'd0, m.err});
        chk1("err_cnt",  m, {12'd0, err_cnt},  {12'd0, m.ec});
        chk1("word_cnt", m, {12'd0, word_cnt}, {12'd0, m.wc});
        if (m.chk_exp) chk1("expected", m, expected, m.expd);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int w;
    rst = 1'b0; valid = 1'b0; din = '0; clr_cnt = 1'b0;
    ec = 4'd0; wc = 4'd0;

    // reset state
    cyc(0, 1, 16'h1234, 0, 0, 0, 1, 16'h0000);
    cyc(0, 1, 16'h1234, 0, 0, 0, 1, 16'h0000);

    // 1: clean stream from seed 0009, lock on 5th word
    tst = 1; g = 16'h0009;
    for (int k = 1; k <= 12; k++) begin
      wc = (k >= 6) ? 4'(k - 5) : 4'd0;
      cyc(1, 1, g, 0, k >= 5, 0, 1,
          (k == 1) ? 16'h0012 : (k == 8) ? 16'h0901 : nxt_m(g));
      g = nxt_m(g);
    end

    // 2: single bit error keeps lock
    tst = 2; ec = 4'd1; wc = 4'd8;
    cyc(1, 1, g ^ 16'h0001, 0, 1, 1, 1, nxt_m(g)); g = nxt_m(g);
    wc = 4'd9;
    cyc(1, 1, g, 0, 1, 0, 1, nxt_m(g)); g = nxt_m(g);

    // 3: three consecutive misses drop lock, then re-lock
    tst = 3;
    for (int i = 0; i < 3; i++) begin
      ec = 4'(2 + i); wc = 4'(10 + i);
      cyc(1, 1, g ^ 16'h8000, 0, i < 2, 1, 1, nxt_m(g)); g = nxt_m(g);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, g, 0, k == 5, 0, 1, nxt_m(g)); g = nxt_m(g);
    end
    wc = 4'd13;
    cyc(1, 1, g, 0, 1, 0, 1, nxt_m(g)); g = nxt_m(g);
    ec = 4'd0; wc = 4'd0;
    cyc(1, 0, 16'hFFFF, 1, 1, 0, 1, g);

    // 4: reset ignores valid; zeros in HUNT ignored; then normal lock
    tst = 4;
    cyc(0, 1, g, 0, 0, 0, 1, 16'h0000);
    for (int k = 0; k < 10; k++) cyc(1, 1, 16'h0000, 0, 0, 0, 1, 16'h0000);
    g = 16'h0009;
    for (int k = 1; k <= 7; k++) begin
      wc = (k >= 6) ? 4'(k - 5) : 4'd0;
      cyc(1, 1, g, 0, k >= 5, 0, 1, nxt_m(g)); g = nxt_m(g);
    end

    // 5: alternating valid gaps with junk data on idle cycles
    tst = 5; wc = 4'd0;
    cyc(0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);
    g = 16'h00A5;
    for (int k = 1; k <= 8; k++) begin
      wc = (k >= 6) ? 4'(k - 5) : 4'd0;
      gexp = nxt_m(g);
      cyc(1, 1, g, 0, k >= 5, 0, 1, gexp);
      cyc(1, 0, 16'hDEAD, 0, k >= 5, 0, 1, gexp);
      g = gexp;
    end

    // 6: saturation, clear-wins, mid-lock reset
    tst = 6;
    for (int i = 1; i <= 20; i++) begin
      ec = (i > 15) ? 4'hF : 4'(i);
      w = 3 + 2 * i - 1;
      wc = (w > 15) ? 4'hF : 4'(w);
      cyc(1, 1, g ^ 16'h0100, 0, 1, 1, 1, nxt_m(g)); g = nxt_m(g);
      w = 3 + 2 * i;
      wc = (w > 15) ? 4'hF : 4'(w);
      cyc(1, 1, g, 0, 1, 0, 1, nxt_m(g)); g = nxt_m(g);
    end
    cyc(1, 1, g ^ 16'h0001, 0, 1, 1, 1, nxt_m(g)); g = nxt_m(g);
    cyc(1, 0, 16'h0000, 0, 1, 0, 1, g);
    ec = 4'd0; wc = 4'd0;
    cyc(1, 1, g ^ 16'h0001, 1, 1, 1, 1, nxt_m(g)); g = nxt_m(g);
    wc = 4'd1;
    cyc(1, 1, g, 0, 1, 0, 1, nxt_m(g)); g = nxt_m(g);
    wc = 4'd0;
    cyc(0, 1, g, 0, 0, 0, 1, 16'h0000);
    cyc(1, 1, 16'h0009, 0, 0, 0, 1, 16'h0012);
    cyc(1, 1, 16'h0012, 0, 0, 0, 1, 16'h0024);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
